// File: rtl/axi_slave_ram_burst_if.sv
// AXI4 bus bundle for the burst RAM slave (AW, W, B, AR, R channels).
// Ports: master drives addresses, write data and ready for B/R; slave drives the rest.
interface axi_slave_ram_burst_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 8
);
    localparam int unsigned STROBE_WIDTH = DATA_WIDTH / 8;

    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [7:0]               awlen;
    logic [2:0]               awsize;
    logic [1:0]               awburst;
    logic                     awvalid;
    logic                     awready;

    logic [DATA_WIDTH-1:0]    wdata;
    logic [STROBE_WIDTH-1:0]  wstrb;
    logic                     wlast;
    logic                     wvalid;
    logic                     wready;

    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;

    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [7:0]               arlen;
    logic [2:0]               arsize;
    logic [1:0]               arburst;
    logic                     arvalid;
    logic                     arready;

    logic [DATA_WIDTH-1:0]    rdata;
    logic [1:0]               rresp;
    logic                     rlast;
    logic                     rvalid;
    logic                     rready;

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_slave_ram_burst.sv
// AXI4 slave over a byte-addressed RAM with independent read/write burst engines.
// Supports FIXED/INCR/WRAP bursts, narrow transfers, byte strobes, OKAY/SLVERR.
// Ports: aclk (clock), areset (sync active-high reset), bus (AXI slave modport).
module axi_slave_ram_burst #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned STROBE_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned ADDRESS_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    axi_slave_ram_burst_if.slave  bus
);
    localparam int unsigned AW        = ADDRESS_WIDTH;
    localparam int unsigned MEM_BYTES = 1 << ADDRESS_WIDTH;
    localparam int unsigned SIZE_MAX  = $clog2(STROBE_WIDTH);
    localparam int unsigned LANE_MASK = STROBE_WIDTH - 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    logic [7:0] mem_q [MEM_BYTES];

    // Unsupported burst type, oversize beat or illegal WRAP length
    function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len);
        return (burst == 2'b11) || (32'(size) > SIZE_MAX) ||
               ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    // Address of the following beat; WRAP stays inside a (len+1)*step aligned container
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [2:0] size,
                                                input logic [1:0] burst, input logic [7:0] len);
        logic [31:0] step;
        logic [31:0] wsz;
        logic [31:0] a32;
        logic [31:0] nxt;
        step = 32'd1 << size;
        a32  = 32'(a);
        wsz  = (32'(len) + 32'd1) * step;
        case (burst)
            2'b00:   nxt = a32;
            2'b10:   nxt = (a32 & ~(wsz - 32'd1)) | ((a32 + step) & (wsz - 32'd1));
            default: nxt = a32 + step;
        endcase
        return AW'(nxt);
    endfunction

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a & ~AW'(LANE_MASK);
    endfunction

    // ---------------- write engine ----------------
    w_state_e              w_state_q;
    logic [AW-1:0]         waddr_q;
    logic [7:0]            wlen_q;
    logic [8:0]            wcnt_q;
    logic [2:0]            wsize_q;
    logic [1:0]            wburst_q;
    logic                  werr_q;
    logic                  wlast_err_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  w_beat_c;
    logic [STROBE_WIDTH-1:0] w_lane_c;

    assign w_beat_c = bus.wvalid && wready_q;

    // Lanes covered by the current beat: size-aligned window inside the bus word
    always_comb begin
        logic [31:0] step;
        logic [31:0] lo;
        w_lane_c = '0;
        step     = 32'd1 << wsize_q;
        lo       = 32'(waddr_q) & LANE_MASK & ~(step - 32'd1);
        for (int unsigned i = 0; i < STROBE_WIDTH; i++) begin
            w_lane_c[i] = (i >= lo) && (i < lo + step);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q   <= W_IDLE;
            waddr_q     <= '0;
            wlen_q      <= '0;
            wcnt_q      <= '0;
            wsize_q     <= '0;
            wburst_q    <= '0;
            werr_q      <= 1'b0;
            wlast_err_q <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (bus.awvalid && awready_q) begin
                        waddr_q     <= bus.awaddr;
                        wlen_q      <= bus.awlen;
                        wcnt_q      <= 9'(bus.awlen) + 9'd1;
                        wsize_q     <= bus.awsize;
                        wburst_q    <= bus.awburst;
                        werr_q      <= burst_err(bus.awsize, bus.awburst, bus.awlen);
                        wlast_err_q <= 1'b0;
                        awready_q   <= 1'b0;
                        wready_q    <= 1'b1;
                        w_state_q   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat_c) begin
                        waddr_q <= next_addr(waddr_q, wsize_q, wburst_q, wlen_q);
                        wcnt_q  <= wcnt_q - 9'd1;
                        if (wcnt_q == 9'd1) begin
                            // Beat counter ends the burst; a missing wlast here is an error
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= (werr_q || wlast_err_q || !bus.wlast) ? 2'b10 : 2'b00;
                            w_state_q <= W_RESP;
                        end else if (bus.wlast) begin
                            wlast_err_q <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid_q && bus.bready) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= 2'b00;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // RAM byte writes; contents intentionally survive reset
    always_ff @(posedge aclk) begin
        if (!areset && w_beat_c && !werr_q) begin
            for (int unsigned i = 0; i < STROBE_WIDTH; i++) begin
                if (bus.wstrb[i] && w_lane_c[i]) begin
                    mem_q[AW'(32'(align(waddr_q)) + i)] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_e              r_state_q;
    logic [AW-1:0]         raddr_q;
    logic [7:0]            rlen_q;
    logic [8:0]            rcnt_q;
    logic [2:0]            rsize_q;
    logic [1:0]            rburst_q;
    logic                  rerr_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;
    logic                  r_ar_err_c;
    logic [AW-1:0]         r_load_addr_c;
    logic [DATA_WIDTH-1:0] rd_word_c;

    assign r_ar_err_c    = burst_err(bus.arsize, bus.arburst, bus.arlen);
    assign r_load_addr_c = (r_state_q == R_IDLE) ? bus.araddr
                                                 : next_addr(raddr_q, rsize_q, rburst_q, rlen_q);

    // Full aligned word for the beat being loaded into the output register
    always_comb begin
        rd_word_c = '0;
        for (int unsigned j = 0; j < STROBE_WIDTH; j++) begin
            rd_word_c[8*j +: 8] = mem_q[AW'(32'(align(r_load_addr_c)) + j)];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rerr_q    <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (bus.arvalid && arready_q) begin
                        raddr_q   <= bus.araddr;
                        rlen_q    <= bus.arlen;
                        rcnt_q    <= 9'(bus.arlen) + 9'd1;
                        rsize_q   <= bus.arsize;
                        rburst_q  <= bus.arburst;
                        rerr_q    <= r_ar_err_c;
                        rdata_q   <= r_ar_err_c ? '0 : rd_word_c;
                        rresp_q   <= r_ar_err_c ? 2'b10 : 2'b00;
                        rlast_q   <= (bus.arlen == 8'd0);
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid_q && bus.rready) begin
                        if (rcnt_q == 9'd1) begin
                            rvalid_q  <= 1'b0;
                            rdata_q   <= '0;
                            rresp_q   <= 2'b00;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            raddr_q <= r_load_addr_c;
                            rcnt_q  <= rcnt_q - 9'd1;
                            rdata_q <= rerr_q ? '0 : rd_word_c;
                            rlast_q <= (rcnt_q == 9'd2);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rlast   = rlast_q;
endmodule

// File: tb/tb_axi_slave_ram_burst.sv
// Scoreboard bench for axi_slave_ram_burst: expected B/R results are queued when
// a burst is issued and popped as the slave presents them.
module tb_axi_slave_ram_burst;
    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;
    localparam logic [1:0] OKAY  = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    axi_slave_ram_burst_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8)) bus ();

    axi_slave_ram_burst #(
        .DATA_WIDTH   (32),
        .STROBE_WIDTH (4),
        .ADDRESS_WIDTH(8)
    ) dut (
        .aclk  (aclk),
        .areset(areset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]  model [256];
    logic [31:0] wbeats [64];
    logic [1:0]  b_exp [$];
    rbeat_t      r_exp [$];

    function automatic logic [31:0] model_word(input logic [7:0] a);
        logic [7:0] b;
        b = a & 8'hFC;
        return {model[b + 8'd3], model[b + 8'd2], model[b + 8'd1], model[b]};
    endfunction

    task automatic set_word(input logic [7:0] a, input logic [31:0] w);
        for (int j = 0; j < 4; j++) model[a + 8'(j)] = w[8*j +: 8];
    endtask

    task automatic push_r(input logic [31:0] d, input logic [1:0] resp, input logic last);
        rbeat_t e;
        e.d = d; e.resp = resp; e.last = last;
        r_exp.push_back(e);
    endtask

    task automatic init_bus();
        bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
    endtask

    // Write burst; caller pushes the expected bresp first. bad_beat flips wlast on that beat.
    task automatic do_write(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] strb, input int bad_beat,
                            input int bready_hold, input string name);
        int n;
        int ilen;
        logic [1:0] e;
        ilen = int'(len);
        bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 20) begin @(negedge aclk); n++; end
        @(negedge aclk);
        bus.awvalid = 1'b0;
        checks++;
        if (bus.wready !== 1'b1) begin
            failures++;
            $display("FAIL %s wready_after_aw got=%b want=1", name, bus.wready);
        end
        for (int i = 0; i <= ilen; i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = wbeats[i];
            bus.wstrb  = strb;
            bus.wlast  = (i == ilen) ^ (i == bad_beat);
            n = 0;
            while (!bus.wready && n < 20) begin @(negedge aclk); n++; end
            @(negedge aclk);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b1) begin
            failures++;
            $display("FAIL %s bvalid_after_last got=%b want=1", name, bus.bvalid);
        end
        for (int k = 0; k < bready_hold; k++) begin
            checks++;
            if (bus.bvalid !== 1'b1 || bus.bresp !== b_exp[0] || bus.awready !== 1'b0) begin
                failures++;
                $display("FAIL %s b_hold cyc=%0d got bvalid=%b bresp=%b awready=%b want 1/%b/0",
                         name, k, bus.bvalid, bus.bresp, bus.awready, b_exp[0]);
            end
            @(negedge aclk);
        end
        bus.bready = 1'b1;
        e = b_exp.pop_front();
        checks++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== e) begin
            failures++;
            $display("FAIL %s bresp got valid=%b resp=%b want valid=1 resp=%b",
                     name, bus.bvalid, bus.bresp, e);
        end
        @(negedge aclk);
        bus.bready = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1) begin
            failures++;
            $display("FAIL %s b_done got bvalid=%b awready=%b want 0/1", name, bus.bvalid, bus.awready);
        end
    endtask

    // Read burst; every cycle with rvalid compares against the queue head (covers hold stability).
    task automatic do_read(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] rpat, input string name);
        int n;
        int k;
        rbeat_t e;
        bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 20) begin @(negedge aclk); n++; end
        @(negedge aclk);
        bus.arvalid = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b1) begin
            failures++;
            $display("FAIL %s rvalid_after_ar got=%b want=1", name, bus.rvalid);
        end
        n = 0;
        k = 0;
        while (r_exp.size() > 0 && n < 200) begin
            bus.rready = rpat[2'(k % 4)];
            k++;
            if (bus.rvalid !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL %s rvalid_drop got=%b want=1", name, bus.rvalid);
                break;
            end
            e = r_exp[0];
            checks++;
            if (bus.rdata !== e.d || bus.rresp !== e.resp || bus.rlast !== e.last) begin
                failures++;
                $display("FAIL %s rbeat got d=%h resp=%b last=%b want d=%h resp=%b last=%b",
                         name, bus.rdata, bus.rresp, bus.rlast, e.d, e.resp, e.last);
            end
            if (bus.rready) void'(r_exp.pop_front());
            @(negedge aclk);
            n++;
        end
        bus.rready = 1'b0;
        checks++;
        if (r_exp.size() != 0 || bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
            failures++;
            $display("FAIL %s r_done left=%0d got rvalid=%b arready=%b want 0/1",
                     name, r_exp.size(), bus.rvalid, bus.arready);
        end
        r_exp.delete();
    endtask

    task automatic test_reset();
        areset = 1'b1;
        init_bus();
        repeat (3) @(negedge aclk);
        checks++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast} !== 6'b0 ||
            bus.bresp !== 2'b00 || bus.rresp !== 2'b00 || bus.rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got aw=%b w=%b b=%b ar=%b r=%b last=%b bresp=%b rresp=%b rdata=%h want all 0",
                     bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast,
                     bus.bresp, bus.rresp, bus.rdata);
        end
        areset = 1'b0;
        @(negedge aclk);
        checks++;
        if (bus.awready !== 1'b1 || bus.arready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got awready=%b arready=%b want 1/1", bus.awready, bus.arready);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 4; j++) begin
                model[4*i + j] = 8'(4*i + j) ^ 8'h5A;
                wbeats[i][8*j +: 8] = 8'(4*i + j) ^ 8'h5A;
            end
        end
        b_exp.push_back(OKAY);
        do_write(8'h00, 8'd63, 3'd2, INCR, 4'hF, -1, 0, "fill");
        push_r(model_word(8'h00), OKAY, 1'b0);
        push_r(model_word(8'h04), OKAY, 1'b1);
        do_read(8'h00, 8'd1, 3'd2, INCR, 4'hF, "fill_readback");
    endtask

    task automatic test_incr();
        for (int i = 0; i < 4; i++) begin
            wbeats[i] = 32'hA0 + 32'(i);
            set_word(8'h10 + 8'(4*i), 32'hA0 + 32'(i));
        end
        b_exp.push_back(OKAY);
        do_write(8'h10, 8'd3, 3'd2, INCR, 4'hF, -1, 0, "incr_write");
        push_r(32'hA0, OKAY, 1'b0);
        push_r(32'hA1, OKAY, 1'b0);
        push_r(32'hA2, OKAY, 1'b0);
        push_r(32'hA3, OKAY, 1'b1);
        do_read(8'h10, 8'd3, 3'd2, INCR, 4'hF, "incr_read");
    endtask

    task automatic test_wrap();
        push_r(model_word(8'h18), OKAY, 1'b0);
        push_r(model_word(8'h1C), OKAY, 1'b0);
        push_r(32'hA0, OKAY, 1'b0);
        push_r(32'hA1, OKAY, 1'b1);
        do_read(8'h18, 8'd3, 3'd2, WRAP, 4'hF, "wrap_read");
    endtask

    task automatic test_narrow();
        wbeats[0] = 32'h0000_5500;
        wbeats[1] = 32'h0055_0000;
        model[8'h21] = 8'h55;
        model[8'h22] = 8'h55;
        b_exp.push_back(OKAY);
        do_write(8'h21, 8'd1, 3'd0, INCR, 4'hF, -1, 0, "narrow_write");
        push_r({8'h23 ^ 8'h5A, 8'h55, 8'h55, 8'h20 ^ 8'h5A}, OKAY, 1'b1);
        do_read(8'h20, 8'd0, 3'd2, INCR, 4'hF, "narrow_read");
    endtask

    task automatic test_errors();
        for (int i = 0; i < 3; i++) push_r(32'h0, SLVERR, i == 2);
        do_read(8'h00, 8'd2, 3'd2, 2'b11, 4'hF, "err_burst11");
        for (int i = 0; i < 3; i++) push_r(32'h0, SLVERR, i == 2);
        do_read(8'h18, 8'd2, 3'd2, WRAP, 4'hF, "err_wrap_len2");
        push_r(32'h0, SLVERR, 1'b1);
        do_read(8'h00, 8'd0, 3'd3, INCR, 4'hF, "err_arsize3");
        wbeats[0] = 32'hFFFF_FFFF;
        b_exp.push_back(SLVERR);
        do_write(8'h30, 8'd0, 3'd3, INCR, 4'hF, -1, 0, "err_awsize3");
        push_r(model_word(8'h30), OKAY, 1'b1);
        do_read(8'h30, 8'd0, 3'd2, INCR, 4'hF, "err_awsize3_mem");
        // Early wlast: still written, but flagged
        wbeats[0] = 32'h1234_5678;
        wbeats[1] = 32'h9ABC_DEF0;
        set_word(8'h60, 32'h1234_5678);
        set_word(8'h64, 32'h9ABC_DEF0);
        b_exp.push_back(SLVERR);
        do_write(8'h60, 8'd1, 3'd2, INCR, 4'hF, 0, 0, "early_wlast");
        push_r(32'h1234_5678, OKAY, 1'b0);
        push_r(32'h9ABC_DEF0, OKAY, 1'b1);
        do_read(8'h60, 8'd1, 3'd2, INCR, 4'hF, "early_wlast_mem");
        // Missing wlast on the final beat
        wbeats[0] = 32'h0BAD_CAFE;
        set_word(8'h68, 32'h0BAD_CAFE);
        b_exp.push_back(SLVERR);
        do_write(8'h68, 8'd0, 3'd2, INCR, 4'hF, 0, 0, "missing_wlast");
    endtask

    task automatic test_backpressure();
        push_r(32'hA0, OKAY, 1'b0);
        push_r(32'hA1, OKAY, 1'b0);
        push_r(32'hA2, OKAY, 1'b0);
        push_r(32'hA3, OKAY, 1'b1);
        do_read(8'h10, 8'd3, 3'd2, INCR, 4'b1001, "rready_pattern");
        wbeats[0] = 32'hCAFE_F00D;
        set_word(8'h70, 32'hCAFE_F00D);
        b_exp.push_back(OKAY);
        do_write(8'h70, 8'd0, 3'd2, INCR, 4'hF, -1, 5, "bready_hold");
        push_r(32'hCAFE_F00D, OKAY, 1'b1);
        do_read(8'h70, 8'd0, 3'd2, INCR, 4'hF, "bready_hold_mem");
    endtask

    task automatic test_back_to_back();
        wbeats[0] = 32'h1111_1111;
        wbeats[1] = 32'h2222_2222;
        wbeats[2] = 32'h3333_3333;
        set_word(8'h50, 32'h3333_3333);
        b_exp.push_back(OKAY);
        do_write(8'h50, 8'd2, 3'd2, FIXED, 4'hF, -1, 0, "fixed_write");
        push_r(32'h3333_3333, OKAY, 1'b0);
        push_r(32'h3333_3333, OKAY, 1'b1);
        do_read(8'h50, 8'd1, 3'd2, FIXED, 4'hF, "fixed_read");
        push_r(model_word(8'h80), OKAY, 1'b0);
        push_r(model_word(8'h84), OKAY, 1'b0);
        push_r(model_word(8'h88), OKAY, 1'b1);
        do_read(8'h80, 8'd2, 3'd2, INCR, 4'hF, "b2b_read");
    endtask

    task automatic test_reset_mid();
        bus.araddr = 8'h40; bus.arlen = 8'd7; bus.arsize = 3'd2; bus.arburst = INCR;
        bus.arvalid = 1'b1;
        @(negedge aclk);
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== model_word(8'h40)) begin
            failures++;
            $display("FAIL mid_beat1 got v=%b d=%h want 1/%h", bus.rvalid, bus.rdata, model_word(8'h40));
        end
        @(negedge aclk);
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== model_word(8'h44)) begin
            failures++;
            $display("FAIL mid_beat2 got v=%b d=%h want 1/%h", bus.rvalid, bus.rdata, model_word(8'h44));
        end
        @(negedge aclk);
        areset = 1'b1;
        bus.rready = 1'b0;
        @(negedge aclk);
        checks++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b0 || bus.rdata !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset got rvalid=%b arready=%b rdata=%h want 0/0/0",
                     bus.rvalid, bus.arready, bus.rdata);
        end
        areset = 1'b0;
        @(negedge aclk);
        checks++;
        if (bus.arready !== 1'b1 || bus.awready !== 1'b1 || bus.rvalid !== 1'b0) begin
            failures++;
            $display("FAIL mid_release got arready=%b awready=%b rvalid=%b want 1/1/0",
                     bus.arready, bus.awready, bus.rvalid);
        end
        push_r(model_word(8'h20), OKAY, 1'b1);
        do_read(8'h20, 8'd0, 3'd2, INCR, 4'hF, "after_reset_mem");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_incr();
        test_wrap();
        test_narrow();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_slave_ram_burst.md
# axi_slave_ram_burst

AXI4 memory-mapped slave with independent read and write engines over a byte-addressed RAM of 2**ADDRESS_WIDTH bytes. It supports FIXED, INCR and WRAP bursts, narrow transfers and byte strobes, and returns OKAY/SLVERR responses. It replaces the read-only burst slave as the simulation and FPGA target memory behind AXI masters in the design.

## Interface
- DATA_WIDTH, 32: data bus width in bits; power of two, 8..256.
- STROBE_WIDTH, DATA_WIDTH/8: byte lanes per beat.
- ADDRESS_WIDTH, 8: byte-address width; memory holds 2**ADDRESS_WIDTH bytes.
- aclk  in  1  single clock; all logic on its rising edge.
- areset  in  1  reset, synchronous and active-high.
- awaddr/awlen/awsize/awburst/awvalid  in  ADDRESS_WIDTH/8/3/2/1  write address channel.
- awready  out  1  write address ready.
- wdata/wstrb/wlast/wvalid  in  DATA_WIDTH/STROBE_WIDTH/1/1  write data channel.
- wready  out  1  write data ready.
- bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr/arlen/arsize/arburst/arvalid  in  ADDRESS_WIDTH/8/3/2/1  read address channel.
- arready  out  1  read address ready.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
- rlast  out  1  last beat of the read burst.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.

## Operation
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. An AW handshake latches addr, len+1 (9-bit beat count), size and burst, then moves to W_DATA.
  - W_DATA: wready=1. Each wvalid&&wready beat writes every byte lane i with wstrb[i]=1 that lies within the active size window. After the final beat, the FSM moves to W_RESP.
  - W_RESP: bvalid=1. bvalid&&bready returns to W_IDLE.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. An AR handshake latches the burst.
  - R_DATA: rvalid=1, beat by beat. rlast is high on the beat whose remaining count is 1. rvalid&&rready on the last beat returns to R_IDLE.
- The internal beat counter is authoritative; wlast does not end a burst. wlast high on a non-final beat, or low on the final beat, sets bresp=SLVERR. All beats are still written.
- Beat address, step 2**size:
  - FIXED (00): constant.
  - INCR (01): +step, modulo 2**ADDRESS_WIDTH.
  - WRAP (10): +step within a container of (len+1)*step bytes aligned to that size.
- Error bursts are fully handshaken with no memory write, and rdata=0. The response is SLVERR on every beat (read) or in B (write) when any of these holds:
  - burst=11;
  - size > log2(STROBE_WIDTH);
  - WRAP with len not in {1,3,7,15}.
- Narrow transfers:
  - Active lanes are addr mod STROBE_WIDTH rounded down to a multiple of 2**size, through 2**size lanes.
  - Strobes outside the active lanes are ignored.
  - rdata always returns the full aligned word.
- Read and write engines run concurrently. A read beat loaded in the same cycle as a write to the same byte returns the old byte.
- Memory contents are not cleared by reset.

## Timing
- While areset=1: awready, wready, bvalid, arready and rvalid are 0; bresp, rresp, rdata and rlast are 0.
- From the first cycle after areset falls: awready=1 and arready=1.
- Reset mid-burst aborts the burst. No further beats or B response are issued, and bytes already written stay written.
- AW handshake in cycle N: wready=1 from N+1.
- Final W beat in cycle M: bvalid=1 from M+1.
- AR handshake in cycle N: rvalid=1 with the first beat data from N+1.
- Each rvalid&&rready presents the next beat in the following cycle, giving 1 beat/cycle sustained.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- rdata, rresp and rlast hold stable while rvalid=1 and rready=0.
- bresp holds stable while bvalid=1 and bready=0.
- awready=0 from W_DATA until the cycle after the B handshake. arready=0 from R_DATA until the cycle after the last R handshake.

## Test plan
- INCR write: awaddr=0x10, len=3, size=2, wdata 0xA0..0xA3, wstrb=F. Then read the same burst -> rdata 0xA0,0xA1,0xA2,0xA3, rlast only on beat 4, bresp=OKAY.
- WRAP read: araddr=0x18, len=3, size=2 -> beats at addresses 0x18, 0x1C, 0x10, 0x14.
- Narrow strobed write: addr=0x21, size=0, len=1, wdata 0x0000_5500 then 0x0055_0000, wstrb=F -> only bytes 0x21=0x55 and 0x22=0x55 change; the rest of the word is unchanged.
- Error bursts: arburst=11 with len=2 -> 3 beats, rresp=10, rdata=0. Write with awsize=3 -> bresp=10 and memory unchanged.
- Backpressure: rready toggles 1,0,0,1 and bready is held low for 5 cycles -> data, rlast and bresp stay stable, and awready stays 0 until the B handshake.
- areset asserted after beat 2 of a len=7 read -> rvalid=0 in the next cycle, and arready=1 in the cycle after areset falls.
